// File: rtl/kan_array_output_collector.sv
// kan_array_output_collector: gathers one result per PE into a frame buffer, then streams
// the frame out row-major over a valid/ready port while holding the array.
module kan_array_output_collector #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int N = ARRAY_SIZE * ARRAY_SIZE,
  localparam int IW = ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*DATA_WIDTH-1:0] pe_data,
  input  logic [N-1:0]            pe_valid,
  input  logic                    clear_status,
  output logic                    array_hold,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [IW-1:0]           m_row,
  output logic [IW-1:0]           m_col,
  output logic                    m_last,
  output logic                    overflow,
  output logic                    timeout,
  output logic [15:0]             frame_count
);
  localparam int XW = N > 1 ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [0:0] state;
  logic [N-1:0] mask, mask_nxt;
  logic [DATA_WIDTH-1:0] buffer [N];
  logic [XW-1:0] idx;
  logic [TW-1:0] cnt, cnt_nxt;
  logic collect, full, tmo_hit, hs, last, ov_set, tmo_set;
  always_comb begin
    collect = state == COLLECT;
    mask_nxt = mask | pe_valid;
    full = &mask_nxt;
    cnt_nxt = cnt + TW'(1);
    // counting starts with the first capture of the frame
    tmo_hit = (|mask_nxt) && cnt_nxt >= TW'(TIMEOUT_CYCLES);
    hs = !collect && m_ready;
    last = idx == XW'(N - 1);
    ov_set = !collect && (|pe_valid);
    tmo_set = collect && !full && tmo_hit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      mask <= '0;
      for (int p = 0; p < N; p++) buffer[p] <= '0;
      idx <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      timeout <= 1'b0;
      frame_count <= '0;
    end else begin
      overflow <= ov_set | (overflow & ~clear_status);
      timeout <= tmo_set | (timeout & ~clear_status);
      if (collect) begin
        for (int p = 0; p < N; p++)
          if (pe_valid[p]) buffer[p] <= pe_data[p*DATA_WIDTH +: DATA_WIDTH];
        mask <= mask_nxt;
        cnt <= (|mask_nxt) ? cnt_nxt : '0;
        if (full || tmo_hit) state <= DRAIN;
      end else if (hs) begin
        if (last) begin
          state <= COLLECT;
          mask <= '0;
          for (int p = 0; p < N; p++) buffer[p] <= '0;
          idx <= '0;
          cnt <= '0;
          frame_count <= frame_count + 16'd1;
        end else begin
          idx <= idx + XW'(1);
        end
      end
    end
  end
  assign array_hold = !collect;
  assign m_valid = !collect;
  assign m_data = collect ? '0 : buffer[idx];
  assign m_row = collect ? '0 : IW'(idx / XW'(ARRAY_SIZE));
  assign m_col = collect ? '0 : IW'(idx % XW'(ARRAY_SIZE));
  assign m_last = !collect && last;
endmodule

// File: doc/kan_array_output_collector.md
KAN_ARRAY_OUTPUT_COLLECTOR -- requirements
Module: kan_array_output_collector

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, rows and columns of the PE array.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of one PE result.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum COLLECT cycles after the first capture.
REQ-004 SHALL define N = ARRAY_SIZE*ARRAY_SIZE and IW = max(1, clog2(ARRAY_SIZE)).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pe_data, input, N*DATA_WIDTH, PE p = row*ARRAY_SIZE+col result at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port pe_valid, input, N, bit p is the output_valid of PE p.
REQ-009 SHALL have port clear_status, input, 1, one-cycle pulse clearing sticky flags.
REQ-010 SHALL have port array_hold, output, 1, high in DRAIN so upstream deasserts the array enable.
REQ-011 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, DATA_WIDTH), m_row and m_col (output, IW each), m_last (output, 1), forming the result stream.
REQ-012 SHALL have ports overflow (output, 1, sticky), timeout (output, 1, sticky) and frame_count (output, 16).

Function
REQ-013 SHALL implement two states: COLLECT and DRAIN.
REQ-014 In COLLECT, SHALL register pe_data slice p into buffer entry p and set mask bit p at every edge where pe_valid[p]=1; any number of bits per cycle.
REQ-015 A repeated pe_valid[p] in COLLECT SHALL overwrite entry p with the newest value, with no error.
REQ-016 The edge at which the updated mask becomes all-ones SHALL move the state to DRAIN; m_valid SHALL be high from the next cycle (1-cycle latency).
REQ-017 After the first capture of a frame, SHALL count COLLECT cycles; on reaching TIMEOUT_CYCLES, SHALL set timeout and enter DRAIN; uncaptured entries drain as zero.
REQ-018 DRAIN SHALL emit entries in index order 0..N-1, one per m_valid&&m_ready handshake, with m_row = index/ARRAY_SIZE, m_col = index%ARRAY_SIZE and m_last=1 only for index N-1.
REQ-019 m_data, m_row, m_col and m_last SHALL remain stable while m_valid=1 and m_ready=0; m_valid SHALL NOT drop without a handshake.
REQ-020 On the m_last handshake, SHALL return to COLLECT, clear the mask, the buffer and the timeout counter, and increment frame_count with wrap from 0xFFFF to 0.
REQ-021 Any pe_valid bit high during a DRAIN cycle, including the last-beat handshake cycle, SHALL be dropped and SHALL set overflow.
REQ-022 array_hold SHALL equal (state==DRAIN); m_valid SHALL be 0 in COLLECT.
REQ-023 clear_status SHALL clear overflow and timeout; a set event in the same cycle SHALL take priority and leave the flag set.

Reset
REQ-024 While rst_n=0, SHALL immediately force: state COLLECT, mask 0, buffer 0, m_valid 0, m_data 0, m_row 0, m_col 0, m_last 0, array_hold 0, overflow 0, timeout 0, frame_count 0, counters 0.
REQ-025 Reset mid-DRAIN SHALL abandon the frame with no further beats; the first rising edge after release SHALL be able to capture.

Verification
REQ-026 ARRAY_SIZE=8: all pe_valid high for one cycle with PE p = 0x0100+p, m_ready=1 -> 64 beats on consecutive cycles, data 0x0100..0x013F, m_last only on beat 63 (row 7, col 7), frame_count=1.
REQ-027 Valids arrive column by column over 8 cycles and m_ready toggles 1/0 -> outputs held stable during stalls, row-major order kept, array_hold high throughout DRAIN.
REQ-028 PE 5 valid twice with 0x0011 then 0x0022 before completion -> beat 5 carries 0x0022 and overflow stays 0.
REQ-029 pe_valid[0] pulsed during DRAIN -> overflow=1 and frame contents unchanged; clear_status pulse -> overflow=0.
REQ-030 TIMEOUT_CYCLES=16, only PE 0 ever valid (0x00AA) -> after 16 cycles timeout=1 and drain gives beat 0=0x00AA, beats 1..63=0.
REQ-031 rst_n asserted after beat 10 of a drain -> m_valid=0 at once; a fresh complete frame after release drains from index 0 with frame_count ending at 1.
